snake_body_store: RTL and testbench
===================================

// Module: snake_body_store
// PURPOSE
// - Holds the snake body as a ring buffer of tile positions; owns head/tail pointers and length.
// - Accepts one head move per game tick; grows the body on eat, otherwise retires the tail.
// - On each scan_start, replays every segment (head first, one per clk) to the VGA renderer
//   on the snake_x/snake_y/first/last/valid stream.
// - Flags self-collision while replaying.
// PARAMETERS
// - MAX_LEN  32  ring depth and maximum snake length; power of two
// - INIT_LEN  3  length after reset/restart; 1..MAX_LEN
// - INIT_X    5  head column after reset/restart; 1-based tile, INIT_X-INIT_LEN+1 >= 1
// - INIT_Y    7  head row after reset/restart; 1-based tile
// PORTS
// - clk           in   1  system clock
// - rst           in   1  synchronous, active-high reset
// - restart       in   1  synchronous game restart; same effect as rst
// - move_valid    in   1  new head position offered
// - move_ready    out  1  high in IDLE; a move transfers when valid&&ready
// - move_x        in   5  new head column
// - move_y        in   4  new head row
// - grow          in   1  sampled with the move; 1 = keep the tail (apple eaten)
// - scan_start    in   1  pulse: start one replay of the body
// - snake_x       out  5  streamed segment column
// - snake_y       out  4  streamed segment row
// - snake_first   out  1  current beat is the head segment
// - snake_last    out  1  current beat is the tail segment
// - snake_valid   out  1  beat valid
// - snake_head_x  out  5  current head column
// - snake_head_y  out  4  current head row
// - length        out  6  current segment count, 1..MAX_LEN
// - full          out  1  length == MAX_LEN
// - self_hit      out  1  sticky: a body segment equals the head
// BEHAVIOUR
// - Reset/restart: ring[0..INIT_LEN-1] = (INIT_X-INIT_LEN+1+i, INIT_Y); tail_ptr=0;
//   head_ptr=INIT_LEN-1; length=INIT_LEN; FSM=IDLE; all stream outputs 0; self_hit=0;
//   move_ready=1. Restart mid-replay aborts it; no further beats are emitted.
// - FSM IDLE->STREAM on scan_start. In STREAM, rd_ptr starts at head_ptr and decrements mod MAX_LEN.
// - Exactly `length` beats are emitted on consecutive cycles, starting the cycle after scan_start.
// - snake_first is set on beat 0; snake_last is set on beat length-1; both are set when length==1.
// - After the last beat, STREAM->IDLE. snake_valid is 0 in IDLE.
// - scan_start while in STREAM is ignored.
// - move_ready = (FSM==IDLE) && !scan_start. A move stalls for the whole replay; the body never
//   changes mid-replay.
// - On move transfer: head_ptr+=1 mod MAX_LEN, and ring[new head_ptr] = (move_x, move_y).
//   - If grow && !full: length+=1.
//   - Otherwise tail_ptr+=1. grow while full is dropped silently and length stays MAX_LEN.
//   - snake_head_x/y update the next cycle.
// - self_hit is set during STREAM when beat index >= 1 and the segment equals (snake_head_x,
//   snake_head_y). It stays set until rst/restart.
// - All outputs are registered. Pointer arithmetic wraps naturally, width log2(MAX_LEN).
// - Coordinates are stored unmodified; range checking belongs to the game logic.
// STRUCTURE
// - snake_pkg holds:
//   - GAME_WIDTH=18 and GAME_HEIGHT=13
//   - typedef struct packed {logic [4:0] x; logic [3:0] y;} tile_pos_t
//   - localparam MAX_LEN
// - Sub-module snake_ring_ram: MAX_LEN x tile_pos_t flop array with one write port, one
//   combinational read port and parallel reset-load of the initial body.
// - The top level holds the pointers, length, the FSM and the collision compare.
// TESTING
// - Reset, then scan_start -> 3 beats on the next 3 cycles: (5,7) first, (4,7), (3,7) last;
//   length=3.
// - Move (6,7) with grow=0, then scan -> (6,7),(5,7),(4,7); length=3; head=(6,7).
// - Move (6,8) with grow=1, then scan -> 4 beats (6,8),(6,7),(5,7),(4,7); snake_last on the 4th.
// - Grow to 32 entries across the ring wrap -> full=1. Move with grow=1 -> length stays 32 and
//   the oldest entry drops.
// - Drive moves (6,7),(6,8),(5,8),(5,7) with grow=1 from reset. Scan -> self_hit rises on the
//   beat carrying (5,7) and stays high.
// - move_valid raised 1 cycle after scan_start -> move_ready low for 3 beats; the move transfers
//   after the replay.
// - Restart asserted on beat 2 -> snake_valid low the next cycle. Rescan -> initial body.

Source files
------------

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared types and constants for the snake body store
// Purpose: playfield dimensions, ring depth and the packed tile position type.
// Ports: none (package).
package snake_pkg;

  localparam int GAME_WIDTH  = 18;
  localparam int GAME_HEIGHT = 13;
  localparam int MAX_LEN     = 32;

  typedef struct packed {
    logic [4:0] x;
    logic [3:0] y;
  } tile_pos_t;

endpackage

// File: rtl/snake_ring_ram.sv
// rtl/snake_ring_ram.sv - flop-array ring storage for the snake body
// Purpose: MAX_LEN tile positions, one write port, one combinational read
//          port, and a parallel load of the initial horizontal body.
// Ports:
//   clk   in  clock
//   load  in  reset-load the initial body (wins over write)
//   we    in  write enable
//   waddr in  write address
//   wdata in  tile written
//   raddr in  read address
//   rdata out tile at raddr (combinational)
module snake_ring_ram #(
  parameter int MAX_LEN  = 32,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 5,
  parameter int INIT_Y   = 7,
  localparam int AW      = $clog2(MAX_LEN)
) (
  input  logic                clk,
  input  logic                load,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  snake_pkg::tile_pos_t wdata,
  input  logic [AW-1:0]       raddr,
  output snake_pkg::tile_pos_t rdata
);
  import snake_pkg::*;

  tile_pos_t mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (load) begin
      // Initial body lies on row INIT_Y, tail at slot 0, head at slot INIT_LEN-1.
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < INIT_LEN) begin
          mem[i].x <= 5'(INIT_X - INIT_LEN + 1 + i);
          mem[i].y <= 4'(INIT_Y);
        end else begin
          mem[i] <= '0;
        end
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/snake_body_store.sv
// rtl/snake_body_store.sv - snake body ring buffer with replay stream
// Purpose: keeps head/tail pointers and length, applies one head move per
//          transfer (grow or retire tail), replays the body head-first on
//          scan_start and flags self-collision during the replay.
// Ports:
//   clk, rst, restart              clock, sync active-high reset, game restart
//   move_valid/move_ready          head move handshake
//   move_x, move_y, grow           new head tile, keep-tail flag
//   scan_start                     start one replay
//   snake_x/y/first/last/valid     replay stream
//   snake_head_x/y                 current head tile
//   length, full                   segment count, length == MAX_LEN
//   self_hit                       sticky head/body collision flag
module snake_body_store #(
  parameter int MAX_LEN  = snake_pkg::MAX_LEN,
  parameter int INIT_LEN = 3,
  parameter int INIT_X   = 5,
  parameter int INIT_Y   = 7,
  localparam int PW      = $clog2(MAX_LEN),
  localparam int LW      = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          restart,
  input  logic          move_valid,
  output logic          move_ready,
  input  logic [4:0]    move_x,
  input  logic [3:0]    move_y,
  input  logic          grow,
  input  logic          scan_start,
  output logic [4:0]    snake_x,
  output logic [3:0]    snake_y,
  output logic          snake_first,
  output logic          snake_last,
  output logic          snake_valid,
  output logic [4:0]    snake_head_x,
  output logic [3:0]    snake_head_y,
  output logic [LW-1:0] length,
  output logic          full,
  output logic          self_hit
);
  import snake_pkg::*;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t        state, state_next;
  logic [PW-1:0] head_ptr, tail_ptr, rd_ptr, rd_addr;
  logic [LW-1:0] beat_idx, load_idx;
  logic          clear, move_fire, load_beat;
  tile_pos_t     rd_data, wr_data;

  assign clear     = rst || restart;
  assign move_fire = move_valid && move_ready;
  assign wr_data   = '{x: move_x, y: move_y};

  // STREAM covers exactly the cycles in which a beat is on the outputs, so
  // the move stall lines up with the visible replay.
  always_comb begin
    state_next = state;
    move_ready = 1'b0;
    load_beat  = 1'b0;
    load_idx   = beat_idx;
    rd_addr    = rd_ptr;
    case (state)
      IDLE: begin
        move_ready = !scan_start;
        rd_addr    = head_ptr;
        load_idx   = '0;
        if (scan_start) begin
          state_next = STREAM;
          load_beat  = 1'b1;
        end
      end
      STREAM: begin
        if (snake_last) state_next = IDLE;
        else            load_beat  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  snake_ring_ram #(
    .MAX_LEN (MAX_LEN),
    .INIT_LEN(INIT_LEN),
    .INIT_X  (INIT_X),
    .INIT_Y  (INIT_Y)
  ) u_ring (
    .clk  (clk),
    .load (clear),
    .we   (move_fire),
    .waddr(head_ptr + 1'b1),
    .wdata(wr_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state        <= IDLE;
      head_ptr     <= PW'(INIT_LEN - 1);
      tail_ptr     <= '0;
      rd_ptr       <= '0;
      beat_idx     <= '0;
      length       <= LW'(INIT_LEN);
      full         <= (INIT_LEN == MAX_LEN);
      snake_head_x <= 5'(INIT_X);
      snake_head_y <= 4'(INIT_Y);
      snake_x      <= '0;
      snake_y      <= '0;
      snake_first  <= 1'b0;
      snake_last   <= 1'b0;
      snake_valid  <= 1'b0;
      self_hit     <= 1'b0;
    end else begin
      state <= state_next;

      if (move_fire) begin
        head_ptr     <= head_ptr + 1'b1;
        snake_head_x <= move_x;
        snake_head_y <= move_y;
        if (grow && !full) begin
          length <= length + 1'b1;
          full   <= (length == LW'(MAX_LEN - 1));
        end else begin
          tail_ptr <= tail_ptr + 1'b1;
        end
      end

      if (load_beat) begin
        snake_x     <= rd_data.x;
        snake_y     <= rd_data.y;
        snake_first <= (state == IDLE);
        snake_last  <= (load_idx == length - 1'b1);
        snake_valid <= 1'b1;
        rd_ptr      <= rd_addr - 1'b1;
        beat_idx    <= load_idx + 1'b1;
        // Body never changes during replay, so the head registers are the
        // head segment for the whole stream.
        if (load_idx != '0 && rd_data.x == snake_head_x && rd_data.y == snake_head_y)
          self_hit <= 1'b1;
      end else begin
        snake_x     <= '0;
        snake_y     <= '0;
        snake_first <= 1'b0;
        snake_last  <= 1'b0;
        snake_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_snake_body_store.sv
// tb/tb_snake_body_store.sv - scoreboard bench for snake_body_store
module tb_snake_body_store;

  logic       clk = 1'b0;
  logic       rst, restart, move_valid, move_ready, grow, scan_start;
  logic [4:0] move_x, snake_x, snake_head_x;
  logic [3:0] move_y, snake_y, snake_head_y;
  logic       snake_first, snake_last, snake_valid, full, self_hit;
  logic [5:0] length;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0] x;
    logic [3:0] y;
    logic       f;
    logic       l;
    logic       sh;
  } beat_t;

  typedef struct packed {
    logic [4:0] x;
    logic [3:0] y;
  } pos_t;

  beat_t sb[$];
  pos_t  model[$];

  snake_body_store dut (
    .clk         (clk),
    .rst         (rst),
    .restart     (restart),
    .move_valid  (move_valid),
    .move_ready  (move_ready),
    .move_x      (move_x),
    .move_y      (move_y),
    .grow        (grow),
    .scan_start  (scan_start),
    .snake_x     (snake_x),
    .snake_y     (snake_y),
    .snake_first (snake_first),
    .snake_last  (snake_last),
    .snake_valid (snake_valid),
    .snake_head_x(snake_head_x),
    .snake_head_y(snake_head_y),
    .length      (length),
    .full        (full),
    .self_hit    (self_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every presented beat is checked against the oldest expectation.
  always @(negedge clk) begin : monitor
    beat_t got;
    beat_t e;
    if (snake_valid) begin
      got = {snake_x, snake_y, snake_first, snake_last, self_hit};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected: got x=%0d y=%0d f=%0b l=%0b sh=%0b expected no beat",
                 got.x, got.y, got.f, got.l, got.sh);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL beat: got x=%0d y=%0d f=%0b l=%0b sh=%0b expected x=%0d y=%0d f=%0b l=%0b sh=%0b",
                   got.x, got.y, got.f, got.l, got.sh, e.x, e.y, e.f, e.l, e.sh);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_beat(input int x, input int y, input int f, input int l, input int sh);
    sb.push_back({5'(x), 4'(y), 1'(f), 1'(l), 1'(sh)});
  endtask

  task automatic model_init();
    model.delete();
    model.push_back({5'd5, 4'd7});
    model.push_back({5'd4, 4'd7});
    model.push_back({5'd3, 4'd7});
  endtask

  task automatic model_move(input int x, input int y, input int g);
    model.push_front({5'(x), 4'(y)});
    if (g == 0 || model.size() > 32) void'(model.pop_back());
  endtask

  task automatic model_to_sb();
    int sh = 0;
    for (int i = 0; i < model.size(); i++) begin
      if (i >= 1 && model[i] == model[0]) sh = 1;
      exp_beat(model[i].x, model[i].y, i == 0, i == model.size() - 1, sh);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    chk(name, sb.size(), 0);
  endtask

  task automatic scan(input string name);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    wait_drain(name);
  endtask

  task automatic do_move(input int x, input int y, input int g);
    int n = 0;
    move_x     = 5'(x);
    move_y     = 4'(y);
    grow       = 1'(g);
    move_valid = 1'b1;
    @(negedge clk);
    while (!move_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!move_ready) chk("move_timeout", 0, 1);
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    grow       = 1'b0;
    model_move(x, y, g);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    model_init();
  endtask

  initial begin
    int stalls;
    int n;
    rst = 1'b1; restart = 1'b0; move_valid = 1'b0; grow = 1'b0; scan_start = 1'b0;
    move_x = '0; move_y = '0;
    repeat (3) tick();
    rst = 1'b0;
    model_init();

    chk("reset_length", length, 3);
    chk("reset_full", full, 0);
    chk("reset_self_hit", self_hit, 0);
    chk("reset_move_ready", move_ready, 1);
    chk("reset_valid", snake_valid, 0);
    chk("reset_head_x", snake_head_x, 5);
    chk("reset_head_y", snake_head_y, 7);

    exp_beat(5, 7, 1, 0, 0);
    exp_beat(4, 7, 0, 0, 0);
    exp_beat(3, 7, 0, 1, 0);
    scan("scan_init");

    do_move(6, 7, 0);
    chk("move1_head_x", snake_head_x, 6);
    chk("move1_head_y", snake_head_y, 7);
    chk("move1_length", length, 3);
    exp_beat(6, 7, 1, 0, 0);
    exp_beat(5, 7, 0, 0, 0);
    exp_beat(4, 7, 0, 1, 0);
    scan("scan_move1");

    do_move(6, 8, 1);
    chk("grow1_length", length, 4);
    exp_beat(6, 8, 1, 0, 0);
    exp_beat(6, 7, 0, 0, 0);
    exp_beat(5, 7, 0, 0, 0);
    exp_beat(4, 7, 0, 1, 0);
    scan("scan_grow1");

    // Five plain moves push head_ptr to 7, then 29 grows wrap it past 31.
    do_restart();
    chk("restart_length", length, 3);
    for (int i = 0; i < 5; i++) do_move(1 + i % 16, 1 + i / 16, 0);
    for (int i = 5; i < 34; i++) do_move(1 + i % 16, 1 + i / 16, 1);
    chk("fill_length", length, 32);
    chk("fill_full", full, 1);
    do_move(1 + 34 % 16, 1 + 34 / 16, 1);
    chk("overgrow_length", length, 32);
    chk("overgrow_full", full, 1);
    chk("overgrow_head_x", snake_head_x, 3);
    chk("overgrow_head_y", snake_head_y, 3);
    model_to_sb();
    scan("scan_full");
    chk("full_self_hit", self_hit, 0);

    do_restart();
    do_move(6, 7, 1);
    do_move(6, 8, 1);
    do_move(5, 8, 1);
    do_move(5, 7, 1);
    chk("loop_length", length, 7);
    exp_beat(5, 7, 1, 0, 0);
    exp_beat(5, 8, 0, 0, 0);
    exp_beat(6, 8, 0, 0, 0);
    exp_beat(6, 7, 0, 0, 0);
    exp_beat(5, 7, 0, 0, 1);
    exp_beat(4, 7, 0, 0, 1);
    exp_beat(3, 7, 0, 1, 1);
    scan("scan_loop");
    tick();
    chk("self_hit_sticky", self_hit, 1);

    do_restart();
    chk("restart_self_hit", self_hit, 0);
    exp_beat(5, 7, 1, 0, 0);
    exp_beat(4, 7, 0, 0, 0);
    exp_beat(3, 7, 0, 1, 0);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    move_x = 5'd6; move_y = 4'd7; grow = 1'b0; move_valid = 1'b1;
    stalls = 0;
    n = 0;
    @(negedge clk);
    while (!move_ready && n < 20) begin
      if (snake_valid) stalls++;
      n++;
      @(negedge clk);
    end
    chk("stall_beats", stalls, 3);
    chk("stall_ready", move_ready, 1);
    chk("stall_valid_at_transfer", snake_valid, 0);
    @(posedge clk);
    #1;
    move_valid = 1'b0;
    model_move(6, 7, 0);
    chk("stall_head_x", snake_head_x, 6);
    chk("stall_drained", sb.size(), 0);

    do_move(6, 8, 1);
    exp_beat(6, 8, 1, 0, 0);
    exp_beat(6, 7, 0, 0, 0);
    exp_beat(5, 7, 0, 0, 0);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    tick();
    tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    model_init();
    chk("abort_valid", snake_valid, 0);
    chk("abort_consumed", sb.size(), 0);
    tick();
    chk("abort_valid_later", snake_valid, 0);
    chk("abort_length", length, 3);
    exp_beat(5, 7, 1, 0, 0);
    exp_beat(4, 7, 0, 0, 0);
    exp_beat(3, 7, 0, 1, 0);
    scan("scan_after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
